lc3b_pmem_arbiter: RTL and testbench
====================================

Name: lc3b_pmem_arbiter

Overview:
Shares the single physical-memory port between the instruction-cache and data-cache miss paths of the pipelined LC-3b core. Sits between both caches and physical memory (or L2). It serialises line fills and writebacks with a 3-state grant FSM and alternates grants on contention. Its per-client resp gates the icache_read/icache_resp fetch stall and the MEM-stage stall.

Parameters:
ADDR_WIDTH, 16, physical byte address width
LINE_WIDTH, 128, cache line width in bits
CNT_WIDTH, 16, width of each saturating grant counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
icache_pmem_read  in  1  icache line-fill request; held until icache_pmem_resp
icache_pmem_address  in  ADDR_WIDTH  icache line address; stable while request held
icache_pmem_rdata  out  LINE_WIDTH  fill data to icache
icache_pmem_resp  out  1  one-cycle completion to icache
dcache_pmem_read  in  1  dcache line-fill request; held until dcache_pmem_resp
dcache_pmem_write  in  1  dcache writeback request; held until dcache_pmem_resp
dcache_pmem_address  in  ADDR_WIDTH  dcache line address
dcache_pmem_wdata  in  LINE_WIDTH  writeback data
dcache_pmem_rdata  out  LINE_WIDTH  fill data to dcache
dcache_pmem_resp  out  1  one-cycle completion to dcache
pmem_read  out  1  read strobe to memory
pmem_write  out  1  write strobe to memory
pmem_address  out  ADDR_WIDTH  address to memory
pmem_wdata  out  LINE_WIDTH  write data to memory
pmem_rdata  in  LINE_WIDTH  read data from memory, valid with pmem_resp
pmem_resp  in  1  memory completion, single cycle
busy  out  1  state != IDLE
icache_grants  out  CNT_WIDTH  saturating count of icache grants
dcache_grants  out  CNT_WIDTH  saturating count of dcache grants

Behaviour:
- States: IDLE, GRANT_I, GRANT_D; registered state, registered last_grant (0=icache, 1=dcache).
- Reset (async, rst_n=0): state=IDLE, last_grant=0, both counters=0. While in reset: all pmem strobes=0, both resp=0, busy=0, rdata outputs=0.
- IDLE transitions: icache request only -> GRANT_I. Any dcache request only (read or write) -> GRANT_D. Both requesting -> grant the client that is not last_grant; after reset, dcache wins first contention. No requests -> stay in IDLE.
- On entering a grant state: last_grant updates and that client's counter increments, saturating at all-ones (no wrap).
- GRANT_I: pmem_read=1, pmem_write=0, pmem_address=icache_pmem_address, pmem_wdata=0.
- GRANT_D: pmem_read=dcache_pmem_read, pmem_write=dcache_pmem_write, pmem_address=dcache_pmem_address, pmem_wdata=dcache_pmem_wdata.
- Data and strobes pass combinationally from the granted client; the grant itself is registered. Minimum latency from request to first pmem strobe is 1 cycle.
- Completion: in a grant state with pmem_resp=1, the granted client's resp=1 in the same cycle and its rdata=pmem_rdata. Next state is IDLE.
- Mandatory IDLE cycle after each completion so the client can drop its request. A request still high in that IDLE cycle is treated as a new request.
- The non-granted client's resp=0 and rdata=0 at all times.
- pmem_resp arriving in IDLE is ignored; no resp is issued and no state changes.
- Request dropped mid-grant (protocol violation): the grant is held until pmem_resp, so memory is never abandoned. Strobes follow the dropped inputs.
- Simultaneous dcache read and write is illegal; both are passed through and not checked.
- rst_n asserted mid-transaction: immediate return to IDLE with strobes low; the in-flight memory access is lost.

Test Plan:
- Reset then icache_pmem_read=1 at 0x1230, pmem_resp after 3 cycles -> pmem_read high cycles 1-4, icache_pmem_resp=1 only in cycle 4 with rdata=pmem_rdata, icache_grants=1, busy low in cycle 5.
- Both requests asserted in the same cycle after reset -> dcache granted first. After its resp plus the IDLE cycle, icache granted; grants alternate D,I,D,I over 4 contended transactions.
- dcache writeback of line 0xA5..A5 to 0x4000 -> pmem_write=1, pmem_wdata matches, pmem_read=0; dcache_pmem_resp pulses for 1 cycle; icache_pmem_resp stays 0.
- pmem_resp pulsed in IDLE with no requests -> no resp outputs, state stays IDLE, counters unchanged.
- rst_n dropped during GRANT_D with pmem_write high -> pmem_write=0 asynchronously and busy=0. After release, a pending icache request is granted first.
- Force icache_grants to 0xFFFE, issue 3 icache transactions -> counter reads 0xFFFF and holds at 0xFFFF.

Source files
------------

// File: rtl/lc3b_pmem_arbiter_if.sv
// rtl/lc3b_pmem_arbiter_if.sv - cache/memory bus bundle for the LC-3b physical-memory arbiter
// slave: the arbiter's view; master: the caches and memory driving it.
interface lc3b_pmem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
);
    logic                  icache_pmem_read;
    logic [ADDR_WIDTH-1:0] icache_pmem_address;
    logic [LINE_WIDTH-1:0] icache_pmem_rdata;
    logic                  icache_pmem_resp;

    logic                  dcache_pmem_read;
    logic                  dcache_pmem_write;
    logic [ADDR_WIDTH-1:0] dcache_pmem_address;
    logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
    logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
    logic                  dcache_pmem_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    logic                  busy;
    logic [CNT_WIDTH-1:0]  icache_grants;
    logic [CNT_WIDTH-1:0]  dcache_grants;

    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output busy, icache_grants, dcache_grants
    );

    modport master (
        output icache_pmem_read, icache_pmem_address,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  busy, icache_grants, dcache_grants
    );
endinterface

// File: rtl/lc3b_pmem_arbiter.sv
// rtl/lc3b_pmem_arbiter.sv - icache/dcache arbiter for the single LC-3b physical-memory port
// Registered grant, combinational pass-through of the granted client's strobes and data.
module lc3b_pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lc3b_pmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0] icache_cnt_q, icache_cnt_d;
    logic [CNT_WIDTH-1:0] dcache_cnt_q, dcache_cnt_d;

    logic icache_req;
    logic dcache_req;

    assign icache_req = bus.icache_pmem_read;
    assign dcache_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

    assign bus.busy          = (state_q != IDLE);
    assign bus.icache_grants = icache_cnt_q;
    assign bus.dcache_grants = dcache_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            icache_cnt_q <= '0;
            dcache_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            icache_cnt_q <= icache_cnt_d;
            dcache_cnt_q <= dcache_cnt_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        last_grant_d          = last_grant_q;
        icache_cnt_d          = icache_cnt_q;
        dcache_cnt_d          = dcache_cnt_q;
        bus.pmem_read         = 1'b0;
        bus.pmem_write        = 1'b0;
        bus.pmem_address      = '0;
        bus.pmem_wdata        = '0;
        bus.icache_pmem_resp  = 1'b0;
        bus.icache_pmem_rdata = '0;
        bus.dcache_pmem_resp  = 1'b0;
        bus.dcache_pmem_rdata = '0;

        unique case (state_q)
            IDLE: begin
                // On contention the client that did not win last time goes next.
                if (icache_req && (!dcache_req || last_grant_q)) begin
                    state_d      = GRANT_I;
                    last_grant_d = 1'b0;
                    if (icache_cnt_q != '1) begin
                        icache_cnt_d = icache_cnt_q + CNT_WIDTH'(1);
                    end
                end else if (dcache_req) begin
                    state_d      = GRANT_D;
                    last_grant_d = 1'b1;
                    if (dcache_cnt_q != '1) begin
                        dcache_cnt_d = dcache_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end

            GRANT_I: begin
                bus.pmem_read    = bus.icache_pmem_read;
                bus.pmem_address = bus.icache_pmem_address;
                if (bus.pmem_resp) begin
                    bus.icache_pmem_resp  = 1'b1;
                    bus.icache_pmem_rdata = bus.pmem_rdata;
                    state_d               = IDLE;
                end
            end

            GRANT_D: begin
                bus.pmem_read    = bus.dcache_pmem_read;
                bus.pmem_write   = bus.dcache_pmem_write;
                bus.pmem_address = bus.dcache_pmem_address;
                bus.pmem_wdata   = bus.dcache_pmem_wdata;
                if (bus.pmem_resp) begin
                    bus.dcache_pmem_resp  = 1'b1;
                    bus.dcache_pmem_rdata = bus.pmem_rdata;
                    state_d               = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_lc3b_pmem_arbiter.sv
// tb/tb_lc3b_pmem_arbiter.sv - scoreboard bench for lc3b_pmem_arbiter
module tb_lc3b_pmem_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;
    localparam int CW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lc3b_pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) bus ();

    lc3b_pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    sb_t sb_i[$];
    sb_t sb_d[$];
    bit  order[$];

    int            i_todo = 0;
    int            d_todo = 0;
    logic [AW-1:0] i_addr = '0;
    logic [AW-1:0] d_addr = '0;
    logic          d_wr_mode = 1'b0;
    logic [LW-1:0] d_wdata = '0;
    bit            abort_d = 1'b0;
    bit            stray_req = 1'b0;
    int            mem_lat = 4;

    logic [AW-1:0] seen_addr;
    logic          seen_rd, seen_wr;
    logic [LW-1:0] seen_wdata;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {8{a}} ^ 128'h0123456789abcdef_fedcba9876543210;
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: answers a strobe after mem_lat strobed cycles with a one-cycle pmem_resp.
    initial begin
        int lat;
        lat = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.pmem_resp = 1'b0;
                lat = 0;
            end else if (bus.pmem_resp) begin
                bus.pmem_resp  = 1'b0;
                bus.pmem_rdata = '0;
                lat = 0;
            end else if (stray_req) begin
                stray_req      = 1'b0;
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = {4{32'hdeadbeef}};
            end else if (bus.pmem_read || bus.pmem_write) begin
                lat++;
                if (lat >= mem_lat) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = line_of(bus.pmem_address);
                    seen_addr      = bus.pmem_address;
                    seen_rd        = bus.pmem_read;
                    seen_wr        = bus.pmem_write;
                    seen_wdata     = bus.pmem_wdata;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Cache clients: raise queued requests, hold until resp, check completions against the scoreboard.
    initial begin
        sb_t e;
        bit  i_done, d_done;
        bus.icache_pmem_read    = 1'b0;
        bus.icache_pmem_address = '0;
        bus.dcache_pmem_read    = 1'b0;
        bus.dcache_pmem_write   = 1'b0;
        bus.dcache_pmem_address = '0;
        bus.dcache_pmem_wdata   = '0;
        forever begin
            @(negedge clk);
            i_done = 1'b0;
            d_done = 1'b0;
            if (abort_d) begin
                bus.dcache_pmem_read  = 1'b0;
                bus.dcache_pmem_write = 1'b0;
                sb_d.delete();
                abort_d = 1'b0;
            end
            if (bus.icache_pmem_resp) begin
                check("i_resp_expected", sb_i.size() != 0, 1);
                if (sb_i.size() != 0) begin
                    e = sb_i.pop_front();
                    check("i_rdata", bus.icache_pmem_rdata, line_of(e.addr));
                    check("i_mem_addr", seen_addr, e.addr);
                    check("i_mem_rd", seen_rd, 1);
                    check("i_mem_wr", seen_wr, 0);
                    check("i_other_resp", bus.dcache_pmem_resp, 0);
                    check("i_other_rdata", bus.dcache_pmem_rdata, 0);
                end
                order.push_back(1'b0);
                bus.icache_pmem_read = 1'b0;
                i_done = 1'b1;
            end
            if (bus.dcache_pmem_resp) begin
                check("d_resp_expected", sb_d.size() != 0, 1);
                if (sb_d.size() != 0) begin
                    e = sb_d.pop_front();
                    check("d_rdata", bus.dcache_pmem_rdata, line_of(e.addr));
                    check("d_mem_addr", seen_addr, e.addr);
                    check("d_mem_rd", seen_rd, !e.wr);
                    check("d_mem_wr", seen_wr, e.wr);
                    if (e.wr) check("d_mem_wdata", seen_wdata, e.wdata);
                    check("d_other_rdata", bus.icache_pmem_rdata, 0);
                end
                order.push_back(1'b1);
                bus.dcache_pmem_read  = 1'b0;
                bus.dcache_pmem_write = 1'b0;
                d_done = 1'b1;
            end
            if (!i_done && !bus.icache_pmem_read && i_todo > 0) begin
                bus.icache_pmem_read    = 1'b1;
                bus.icache_pmem_address = i_addr;
                sb_i.push_back('{addr: i_addr, wr: 1'b0, wdata: '0});
                i_addr = i_addr + 16'h0010;
                i_todo--;
            end
            if (!d_done && !bus.dcache_pmem_read && !bus.dcache_pmem_write && d_todo > 0) begin
                bus.dcache_pmem_read    = !d_wr_mode;
                bus.dcache_pmem_write   = d_wr_mode;
                bus.dcache_pmem_address = d_addr;
                bus.dcache_pmem_wdata   = d_wdata;
                sb_d.push_back('{addr: d_addr, wr: d_wr_mode, wdata: d_wdata});
                d_addr = d_addr + 16'h0010;
                d_todo--;
            end
        end
    end

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            if (i_todo == 0 && d_todo == 0 && !bus.icache_pmem_read && !bus.dcache_pmem_read &&
                !bus.dcache_pmem_write && !bus.busy && sb_i.size() == 0 && sb_d.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit       ok;
        logic [3:0] ord;
        logic     pr[1:5];
        logic     ir[1:5];
        logic     bz[1:5];

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_pmem_read", bus.pmem_read, 0);
        check("rst_pmem_write", bus.pmem_write, 0);
        check("rst_i_resp", bus.icache_pmem_resp, 0);
        check("rst_d_resp", bus.dcache_pmem_resp, 0);
        check("rst_i_rdata", bus.icache_pmem_rdata, 0);
        check("rst_i_grants", bus.icache_grants, 0);
        check("rst_d_grants", bus.dcache_grants, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Single icache fill at 0x1230, memory answers in the 4th granted cycle
        mem_lat = 4;
        i_addr  = 16'h1230;
        i_todo  = 1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            if (bus.icache_pmem_read) begin
                ok = 1'b1;
                break;
            end
        end
        check("t1_req_seen", ok, 1);
        check("t1_addr", bus.pmem_address, 16'h1230);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                @(posedge clk); #2;
            end
            pr[c] = bus.pmem_read;
            ir[c] = bus.icache_pmem_resp;
            bz[c] = bus.busy;
        end
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("t1_pmem_read_c%0d", c), pr[c], 1);
            check($sformatf("t1_i_resp_c%0d", c), ir[c], (c == 4) ? 1 : 0);
        end
        check("t1_pmem_read_c5", pr[5], 0);
        check("t1_busy_c5", bz[5], 0);
        wait_idle("t1_done");
        check("t1_i_grants", bus.icache_grants, 1);
        check("t1_d_grants", bus.dcache_grants, 0);

        // pmem_resp in IDLE with no requests is ignored
        stray_req = 1'b1;
        @(posedge clk); #2;
        check("stray_i_resp", bus.icache_pmem_resp, 0);
        check("stray_d_resp", bus.dcache_pmem_resp, 0);
        check("stray_busy", bus.busy, 0);
        @(posedge clk); #2;
        check("stray_busy_next", bus.busy, 0);
        check("stray_i_grants", bus.icache_grants, 1);
        check("stray_d_grants", bus.dcache_grants, 0);

        // dcache writeback of an 0xA5 line to 0x4000
        d_wr_mode = 1'b1;
        d_addr    = 16'h4000;
        d_wdata   = {16{8'hA5}};
        order.delete();
        d_todo    = 1;
        wait_idle("wb_done");
        check("wb_n", order.size(), 1);
        check("wb_d_grants", bus.dcache_grants, 1);
        check("wb_i_grants", bus.icache_grants, 1);

        // Asynchronous reset during a dcache writeback; pending icache request wins afterwards
        mem_lat = 50;
        d_addr  = 16'h4100;
        d_todo  = 1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            if (bus.pmem_write) begin
                ok = 1'b1;
                break;
            end
        end
        check("ar_write_seen", ok, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("ar_pmem_write", bus.pmem_write, 0);
        check("ar_busy", bus.busy, 0);
        check("ar_d_resp", bus.dcache_pmem_resp, 0);
        abort_d = 1'b1;
        order.delete();
        i_addr  = 16'h2200;
        i_todo  = 1;
        repeat (3) @(posedge clk);
        mem_lat = 4;
        #2;
        rst_n = 1'b1;
        wait_idle("ar_done");
        check("ar_n", order.size(), 1);
        if (order.size() != 0) check("ar_first", order[0], 0);
        check("ar_i_grants", bus.icache_grants, 1);
        check("ar_d_grants", bus.dcache_grants, 0);

        // Four contended transactions: dcache first, then alternating
        order.delete();
        d_wr_mode = 1'b0;
        d_addr    = 16'h8000;
        i_addr    = 16'h2000;
        i_todo    = 2;
        d_todo    = 2;
        wait_idle("cont_done");
        check("cont_n", order.size(), 4);
        ord = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) ord[3-i] = order[i];
        end
        check("cont_order", ord, 4'b1010);
        check("cont_i_grants", bus.icache_grants, 3);
        check("cont_d_grants", bus.dcache_grants, 2);

        // Counter saturation from 0xFFFE
        dut.icache_cnt_q = 16'hFFFE;
        i_todo = 3;
        wait_idle("sat_done");
        check("sat_i_grants", bus.icache_grants, 16'hFFFF);
        check("sat_d_grants", bus.dcache_grants, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
